data_mem_stage: RTL and testbench
=================================

// Module: data_mem_stage
// PURPOSE
//  Memory-access stage that sits directly downstream of the ALU. It takes the ALU's
//  10-bit byte address and the store data from the register file, and performs
//  byte, halfword and word loads and stores on an internal synchronous word RAM.
//  Alignment is checked and load data is extended before it returns to write-back.
//  The valid/ready request handshake lets the CPU control stall while an access is
//  in flight.
// PARAMETERS
//  ADDR_W  10  byte-address width; RAM depth = 2**(ADDR_W-2) 32-bit words
//  DATA_W  32  data width; fixed at 32 (byte lanes assume 4 bytes/word)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous reset, active-low (0 = reset)
//  req_valid  in   1       access request present
//  req_ready  out  1       stage can accept a request (state IDLE)
//  req_we     in   1       1 = store, 0 = load
//  req_size   in   2       00 = byte, 01 = half, 10 = word, 11 = illegal
//  req_sign   in   1       loads: 1 = sign-extend, 0 = zero-extend
//  req_addr   in   ADDR_W  byte address (ALU result)
//  req_wdata  in   DATA_W  store data; low byte/half is used for sub-word stores
//  rsp_valid  out  1       one-cycle pulse: access complete
//  rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
//  rsp_err    out  1       qualifies rsp_valid: access rejected, no RAM effect
//  busy       out  1       ~req_ready; drives the CPU stall
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0;
//    req_ready=0 while reset is held, then 1. RAM contents are not cleared.
//  - Accept: request is taken on a rising edge with req_valid & req_ready. All req_*
//    fields are latched on that edge; later input changes are ignored.
//  - FSM: IDLE -(accept, legal, load)-> RD -> RESP -> IDLE
//         IDLE -(accept, legal, store)-> WR -> RESP -> IDLE
//         IDLE -(accept, illegal)-> RESP(err) -> IDLE
//  - Latency: rsp_valid is high in the 2nd cycle after accept for legal accesses and
//    the 1st cycle after accept for errors. Next accept earliest is the cycle after RESP.
//    There is no response backpressure.
//  - Word index = addr[ADDR_W-1:2]; lane = addr[1:0]; little-endian.
//  - RD: synchronous RAM read. RESP presents the selected lane/half, extended per the
//    latched req_sign. A word load ignores req_sign.
//  - WR: byte-enable write on the WR-state edge. Byte writes lane addr[1:0]; half
//    writes lanes {addr[1],1'b?}; word writes all lanes. Unwritten lanes are untouched.
//  - Legality: size=11 is always illegal. Misalignment (half with addr[0]=1, word with
//    addr[1:0]!=0) is handled per CONFIGURATION.
//  - The top word (addr 2**ADDR_W-4) is legal. There is no address wrap inside an
//    access, because aligned accesses never cross a word.
//  - Reset mid-operation: FSM returns to IDLE immediately and no response is issued.
//    Reset during WR before the commit edge means the RAM is unchanged.
//  - rsp_rdata and rsp_err hold their value outside RESP; only rsp_valid qualifies them.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: a misaligned half or word is illegal. It produces
//    rsp_err=1 and rsp_rdata=0, with no RAM read or write.
//  MISALIGN_TRAP_EN undefined: low address bits below the access size are forced to 0
//    (half: addr[0]; word: addr[1:0]) and the access proceeds normally. rsp_err is
//    asserted only for size=11.
// TESTING
//  1 Store word 0xDEADBEEF @0x010, then load word @0x010 -> rsp_valid 2 cycles after
//    each accept; rdata=0xDEADBEEF, err=0.
//  2 Load signed byte @0x013 -> 0xFFFFFFDE. Load unsigned half @0x012 -> 0x0000DEAD.
//    Load signed half @0x010 -> 0xFFFFBEEF.
//  3 Store byte 0x5A @0x011, then load word @0x010 -> 0xDEAD5AEF (other lanes kept).
//  4 Load word @0x012: with MISALIGN_TRAP_EN -> err=1, rdata=0, 1-cycle latency, RAM
//    unchanged. Without it -> 0xDEAD5AEF from @0x010, err=0. size=11 -> err=1 in both builds.
//  5 Hold req_valid high with back-to-back requests -> req_ready low in RD/WR/RESP.
//    Exactly one rsp_valid per accept; word store/load at top address 0x3FC succeeds.
//  6 Assert reset=0 during WR of word 0x12345678 @0x020 -> no rsp_valid; after release,
//    load @0x020 returns the prior contents and req_ready=1.

Source files
------------

// File: rtl/data_mem_stage_if.sv
// Request/response bundle between the CPU pipeline and the data memory stage.
// The CPU drives the request side; the memory stage drives the response side.
interface data_mem_stage_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_stage.sv
// Memory-access stage: byte/half/word loads and stores on an internal word RAM
// built from per-byte-lane arrays. Optional feature macro: MISALIGN_TRAP_EN.
module data_mem_lane #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wd,
    output logic [7:0]       rd
);
    logic [7:0] mem [0:(1<<IDX_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wd;
    end

    assign rd = mem[idx];
endmodule

module data_mem_stage #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic reset,
    data_mem_stage_if.slave bus
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int IDX_W     = ADDR_W - 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]        state;
    logic              we_q, sign_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept, illegal;
    logic [ADDR_W-1:0] addr_in;

    assign bus.req_ready = reset & (state == IDLE);
    assign bus.busy      = ~bus.req_ready;
    assign bus.rsp_valid = (state == RESP);
    assign accept        = bus.req_valid & bus.req_ready;

`ifdef MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                      ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
    assign illegal  = (bus.req_size == 2'b11) | misalign;
    assign addr_in  = bus.req_addr;
`else
    assign illegal = (bus.req_size == 2'b11);
    // Drop the address bits below the access size so the access is aligned.
    always_comb begin
        addr_in = bus.req_addr;
        case (bus.req_size)
            2'b01:   addr_in[0]   = 1'b0;
            2'b10:   addr_in[1:0] = 2'b00;
            default: addr_in      = bus.req_addr;
        endcase
    end
`endif

    logic [NUM_LANES-1:0]        be;
    logic [NUM_LANES-1:0][7:0]   wlanes;
    logic [NUM_LANES-1:0][7:0]   rlanes;
    logic [DATA_W-1:0]           rword;
    logic [7:0]                  byte_v;
    logic [15:0]                 half_v;
    logic [DATA_W-1:0]           load_ext;

    always_comb begin
        be     = '0;
        wlanes = wdata_q;
        case (size_q)
            2'b00: begin
                be[addr_q[1:0]] = 1'b1;
                wlanes          = {NUM_LANES{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            2'b10:   be = '1;
            default: be = '0;
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        data_mem_lane #(.IDX_W(IDX_W)) u_lane (
            .clk (clk),
            .we  (be[g] & (state == WR)),
            .idx (addr_q[ADDR_W-1:2]),
            .wd  (wlanes[g]),
            .rd  (rlanes[g])
        );
    end

    assign rword  = rlanes;
    assign byte_v = rlanes[addr_q[1:0]];
    assign half_v = addr_q[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{sign_q & byte_v[7]}}, byte_v};
            2'b01:   load_ext = {{16{sign_q & half_v[15]}}, half_v};
            default: load_ext = rword;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            sign_q        <= 1'b0;
            size_q        <= 2'b00;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we_q    <= bus.req_we;
                    sign_q  <= bus.req_sign;
                    size_q  <= bus.req_size;
                    addr_q  <= addr_in;
                    wdata_q <= bus.req_wdata;
                    if (illegal) begin
                        state         <= RESP;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end else begin
                        state <= bus.req_we ? WR : RD;
                    end
                end
                RD: begin
                    state         <= RESP;
                    bus.rsp_rdata <= load_ext;
                    bus.rsp_err   <= 1'b0;
                end
                // RAM commit happens on this same edge via the lane write enables.
                WR: begin
                    state         <= RESP;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_we;
    assign unused_we = we_q;
endmodule

// File: tb/tb_data_mem_stage.sv
// Directed, table-driven bench for data_mem_stage plus hand sequences for
// back-to-back requests and reset during a store.
module tb_data_mem_stage;
    logic clk;
    logic reset;

    data_mem_stage_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    data_mem_stage #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic we, input logic [1:0] size,
                                input logic sign, input logic [9:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.name = nm; v.we = we; v.size = size; v.sign = sign; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic run_access(input vec_t v);
        int lat;
        int w;
        bit got;
        @(negedge clk);
        bus.req_we    = v.we;
        bus.req_size  = v.size;
        bus.req_sign  = v.sign;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({v.name, " ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request after accept; the stage must use the latched copy.
        bus.req_valid = 1'b0;
        bus.req_we    = ~v.we;
        bus.req_size  = 2'b11;
        bus.req_sign  = ~v.sign;
        bus.req_addr  = ~v.addr;
        bus.req_wdata = 32'h0BAD0BAD;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) got = 1'b1;
        end
        check({v.name, " lat"}, lat, v.exp_lat);
        check({v.name, " rdata"}, bus.rsp_rdata, v.exp_rdata);
        check({v.name, " err"}, {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
        @(negedge clk);
        check({v.name, " pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int nacc;
        int nrsp;
        int bad;
        vecs.push_back(mk("st_w_010",   1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0, 2));
        vecs.push_back(mk("ld_w_010",   0, 2'b10, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0, 2));
        vecs.push_back(mk("ld_sb_013",  0, 2'b00, 1, 10'h013, 32'h0, 32'hFFFFFFDE, 0, 2));
        vecs.push_back(mk("ld_uh_012",  0, 2'b01, 0, 10'h012, 32'h0, 32'h0000DEAD, 0, 2));
        vecs.push_back(mk("ld_sh_010",  0, 2'b01, 1, 10'h010, 32'h0, 32'hFFFFBEEF, 0, 2));
        vecs.push_back(mk("st_b_011",   1, 2'b00, 0, 10'h011, 32'hAABBCC5A, 32'h0, 0, 2));
        vecs.push_back(mk("ld_w_010b",  0, 2'b10, 0, 10'h010, 32'h0, 32'hDEAD5AEF, 0, 2));
        vecs.push_back(mk("ld_w_mis",   0, 2'b10, 0, 10'h012, 32'h0,
                          TRAP ? 32'h0 : 32'hDEAD5AEF, TRAP, TRAP ? 1 : 2));
        vecs.push_back(mk("ld_sz11",    0, 2'b11, 0, 10'h010, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk("st_sz11",    1, 2'b11, 0, 10'h010, 32'h11111111, 32'h0, 1, 1));
        vecs.push_back(mk("ld_w_010c",  0, 2'b10, 1, 10'h010, 32'h0, 32'hDEAD5AEF, 0, 2));
        vecs.push_back(mk("ld_ub_011",  0, 2'b00, 0, 10'h011, 32'h0, 32'h0000005A, 0, 2));
        vecs.push_back(mk("ld_sb_010",  0, 2'b00, 1, 10'h010, 32'h0, 32'hFFFFFFEF, 0, 2));
        vecs.push_back(mk("st_w_014",   1, 2'b10, 0, 10'h014, 32'h11223344, 32'h0, 0, 2));
        vecs.push_back(mk("st_h_016",   1, 2'b01, 0, 10'h016, 32'h12348001, 32'h0, 0, 2));
        vecs.push_back(mk("ld_sh_016",  0, 2'b01, 1, 10'h016, 32'h0, 32'hFFFF8001, 0, 2));
        vecs.push_back(mk("st_h_mis",   1, 2'b01, 0, 10'h015, 32'h0000BEEF, 32'h0, TRAP, TRAP ? 1 : 2));
        vecs.push_back(mk("ld_w_014",   0, 2'b10, 0, 10'h014, 32'h0,
                          TRAP ? 32'h80013344 : 32'h8001BEEF, 0, 2));
        vecs.push_back(mk("st_w_3fc",   1, 2'b10, 0, 10'h3FC, 32'hCAFEF00D, 32'h0, 0, 2));
        vecs.push_back(mk("ld_w_3fc",   0, 2'b10, 0, 10'h3FC, 32'h0, 32'hCAFEF00D, 0, 2));
        vecs.push_back(mk("ld_sb_3ff",  0, 2'b00, 1, 10'h3FF, 32'h0, 32'hFFFFFFCA, 0, 2));
        vecs.push_back(mk("st_w_020",   1, 2'b10, 0, 10'h020, 32'hA5A5A5A5, 32'h0, 0, 2));

        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_sign  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #12;
        check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        check("rst req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst busy",      {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post-rst req_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_access(vecs[i]);

        // Back-to-back loads with req_valid held high: accept every third cycle.
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_sign = 1'b0;
        bus.req_addr = 10'h3FC; bus.req_valid = 1'b1;
        nacc = 0; nrsp = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            check("b2b ready", {31'd0, bus.req_ready}, {31'd0, (i % 3) == 0});
            check("b2b busy", {31'd0, bus.busy}, {31'd0, ~bus.req_ready});
            if (bus.req_ready) nacc++;
            if (bus.rsp_valid) begin
                nrsp++;
                check("b2b rdata", bus.rsp_rdata, 32'hCAFEF00D);
            end
        end
        bus.req_valid = 1'b0;
        check("b2b accepts", nacc, 3);
        check("b2b responses", nrsp, 3);
        @(negedge clk);

        // Reset asserted while the store sits in WR: no commit, no response.
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_sign = 1'b0;
        bus.req_addr = 10'h020; bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
        check("wr-rst ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("wr-rst valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("wr-rst ready held", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.rsp_valid || !bus.req_ready) bad++;
            @(negedge clk);
        end
        check("wr-rst idle after release", bad, 0);
        run_access(mk("ld_w_020", 0, 2'b10, 0, 10'h020, 32'h0, 32'hA5A5A5A5, 0, 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
